// File: rtl/discriminated_stream_expander.sv
// discriminated_stream_expander
//   Rebuilds a dense, time-aligned batch stream from one channel's sparse
//   discriminator output and its timestamp records. Every record opens a
//   segment of contiguous kept batches. Batch periods that fall between
//   segments are filled with FILL_WORD batches that are flagged kept=0.
//
// Ports
//   clk, reset           clock; synchronous active-high reset
//   cfg_decimation       time units per batch (0 is treated as 1), latched on
//                        the first record of a frame
//   s_tstamp_*           record stream {time, index}; last marks the final record
//   s_data_*             sparse batch stream; last marks the final sparse batch
//   m_data_*             dense batch stream; last is set on the final dense batch
//   m_kept               1 = copied batch, 0 = fill batch (qualified by m_data_valid)
//   error                sticky protocol/timing error flag, cleared only by reset
module discriminated_stream_expander #(
    parameter int                    DATA_WIDTH         = 16,
    parameter int                    TSTAMP_WIDTH       = 32,
    parameter int                    SAMPLE_INDEX_WIDTH = 16,
    parameter int                    DECIMATION_BITS    = 8,
    parameter logic [DATA_WIDTH-1:0] FILL_WORD          = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DECIMATION_BITS-1:0] cfg_decimation,
    input  logic [TSTAMP_WIDTH-1:0]    s_tstamp_data,
    input  logic                       s_tstamp_valid,
    output logic                       s_tstamp_ready,
    input  logic                       s_tstamp_last,
    input  logic [DATA_WIDTH-1:0]      s_data_data,
    input  logic                       s_data_valid,
    output logic                       s_data_ready,
    input  logic                       s_data_last,
    output logic [DATA_WIDTH-1:0]      m_data_data,
    output logic                       m_data_valid,
    input  logic                       m_data_ready,
    output logic                       m_data_last,
    output logic                       m_kept,
    output logic                       error
);
    localparam int TIME_WIDTH = TSTAMP_WIDTH - SAMPLE_INDEX_WIDTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_COPY  = 3'd2;
    localparam logic [2:0] S_GAP   = 3'd3;
    localparam logic [2:0] S_FILL  = 3'd4;

    logic [2:0]                    state;
    logic [TIME_WIDTH-1:0]         exp_time;
    logic [SAMPLE_INDEX_WIDTH-1:0] data_idx;
    logic [DECIMATION_BITS-1:0]    dec;
    logic                          cur_last;
    logic [TIME_WIDTH-1:0]         nxt_time;
    logic [SAMPLE_INDEX_WIDTH-1:0] nxt_index;
    logic                          nxt_last;
    logic                          nxt_vld;

    logic [TIME_WIDTH-1:0]         s_time;
    logic [SAMPLE_INDEX_WIDTH-1:0] s_index;
    logic [TIME_WIDTH-1:0]         exp_next;
    logic [SAMPLE_INDEX_WIDTH-1:0] idx_next;
    logic signed [TIME_WIDTH-1:0]  gap_diff;
    logic signed [TIME_WIDTH-1:0]  fill_diff;
    logic                          out_free;
    logic                          seg_done;
    logic                          copy_xfer;

    assign s_time    = s_tstamp_data[TSTAMP_WIDTH-1:SAMPLE_INDEX_WIDTH];
    assign s_index   = s_tstamp_data[SAMPLE_INDEX_WIDTH-1:0];
    assign exp_next  = exp_time + TIME_WIDTH'(dec);
    assign idx_next  = data_idx + SAMPLE_INDEX_WIDTH'(1);
    // Differences are taken modulo 2^TIME_WIDTH so timestamp wrap is legal.
    assign gap_diff  = nxt_time - exp_time;
    assign fill_diff = nxt_time - exp_next;
    assign out_free  = !m_data_valid || m_data_ready;
    // Segment already exhausted on entry (zero-length segment).
    assign seg_done  = nxt_vld && (data_idx == nxt_index);

    assign s_tstamp_ready = !reset && ((state == S_IDLE) || (state == S_FETCH && !cur_last));
    assign s_data_ready   = !reset && (state == S_COPY) && !seg_done && out_free;
    assign copy_xfer      = s_data_ready && s_data_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            exp_time     <= '0;
            data_idx     <= '0;
            dec          <= DECIMATION_BITS'(1);
            cur_last     <= 1'b0;
            nxt_time     <= '0;
            nxt_index    <= '0;
            nxt_last     <= 1'b0;
            nxt_vld      <= 1'b0;
            m_data_data  <= '0;
            m_data_valid <= 1'b0;
            m_data_last  <= 1'b0;
            m_kept       <= 1'b0;
            error        <= 1'b0;
        end else begin
            if (m_data_valid && m_data_ready)
                m_data_valid <= 1'b0;

            case (state)
                S_IDLE: if (s_tstamp_valid) begin
                    exp_time <= s_time;
                    dec      <= (cfg_decimation == '0) ? DECIMATION_BITS'(1) : cfg_decimation;
                    cur_last <= s_tstamp_last;
                    data_idx <= '0;
                    if (s_index != '0)
                        error <= 1'b1;
                    state    <= S_FETCH;
                end
                S_FETCH: begin
                    if (cur_last) begin
                        nxt_vld <= 1'b0;
                        state   <= S_COPY;
                    end else if (s_tstamp_valid) begin
                        nxt_time  <= s_time;
                        nxt_index <= s_index;
                        nxt_last  <= s_tstamp_last;
                        nxt_vld   <= 1'b1;
                        state     <= S_COPY;
                    end
                end
                S_COPY: begin
                    if (seg_done) begin
                        state <= S_GAP;
                    end else if (copy_xfer) begin
                        m_data_valid <= 1'b1;
                        m_data_data  <= s_data_data;
                        m_kept       <= 1'b1;
                        m_data_last  <= s_data_last;
                        data_idx     <= idx_next;
                        exp_time     <= exp_next;
                        if (s_data_last) begin
                            // Sparse stream ended while records were still pending.
                            if (nxt_vld)
                                error <= 1'b1;
                            state <= S_IDLE;
                        end else if (nxt_vld && idx_next == nxt_index) begin
                            state <= S_GAP;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_diff > 0) begin
                        state <= S_FILL;
                    end else begin
                        // Negative gap: next segment starts in the past; resync, no fill.
                        if (gap_diff < 0) begin
                            error    <= 1'b1;
                            exp_time <= nxt_time;
                        end
                        cur_last <= nxt_last;
                        state    <= S_FETCH;
                    end
                end
                S_FILL: if (out_free) begin
                    m_data_valid <= 1'b1;
                    m_data_data  <= FILL_WORD;
                    m_kept       <= 1'b0;
                    m_data_last  <= 1'b0;
                    if (fill_diff > 0) begin
                        exp_time <= exp_next;
                    end else begin
                        // Overshoot: record time is off the decimation grid.
                        if (fill_diff < 0) begin
                            error    <= 1'b1;
                            exp_time <= nxt_time;
                        end else begin
                            exp_time <= exp_next;
                        end
                        cur_last <= nxt_last;
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_discriminated_stream_expander.sv
module tb_discriminated_stream_expander;
    localparam int DW  = 16;
    localparam int TSW = 16;
    localparam int SIW = 8;
    localparam int DB  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DB-1:0] cfg_decimation = 8'd1;
    logic [TSW-1:0] s_tstamp_data = '0;
    logic          s_tstamp_valid = 1'b0;
    logic          s_tstamp_ready;
    logic          s_tstamp_last = 1'b0;
    logic [DW-1:0] s_data_data = '0;
    logic          s_data_valid = 1'b0;
    logic          s_data_ready;
    logic          s_data_last = 1'b0;
    logic [DW-1:0] m_data_data;
    logic          m_data_valid;
    logic          m_data_ready = 1'b1;
    logic          m_data_last;
    logic          m_kept;
    logic          error;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    discriminated_stream_expander #(
        .DATA_WIDTH(DW), .TSTAMP_WIDTH(TSW), .SAMPLE_INDEX_WIDTH(SIW),
        .DECIMATION_BITS(DB), .FILL_WORD('0)
    ) dut (
        .clk(clk), .reset(reset), .cfg_decimation(cfg_decimation),
        .s_tstamp_data(s_tstamp_data), .s_tstamp_valid(s_tstamp_valid),
        .s_tstamp_ready(s_tstamp_ready), .s_tstamp_last(s_tstamp_last),
        .s_data_data(s_data_data), .s_data_valid(s_data_valid),
        .s_data_ready(s_data_ready), .s_data_last(s_data_last),
        .m_data_data(m_data_data), .m_data_valid(m_data_valid),
        .m_data_ready(m_data_ready), .m_data_last(m_data_last),
        .m_kept(m_kept), .error(error)
    );

    logic [16:0] ts_q[$];   // {last, time[7:0], index[7:0]}
    logic [16:0] dq[$];     // {last, data}
    logic [17:0] exp_q[$];  // {last, kept, data}
    logic [17:0] got_q[$];
    int          got_cyc[$];
    int          lasts = 0;
    int          checks = 0;
    int          errors = 0;

    // Output monitor: a transfer is visible at the negedge preceding its edge.
    always @(negedge clk) begin
        if (!reset && m_data_valid && m_data_ready) begin
            got_q.push_back({m_data_last, m_kept, m_data_data});
            got_cyc.push_back(cyc);
            if (m_data_last) lasts++;
        end
    end

    function automatic logic [16:0] ts(input int t, input int i, input bit l);
        ts = {l, t[7:0], i[7:0]};
    endfunction

    function automatic logic [16:0] bt(input int n, input bit l);
        bt = {l, 16'hA000 + n[15:0]};
    endfunction

    function automatic logic [17:0] ek(input int n, input bit l);
        ek = {l, 1'b1, 16'hA000 + n[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic feed_ts();
        foreach (ts_q[i]) begin
            s_tstamp_data  = ts_q[i][15:0];
            s_tstamp_last  = ts_q[i][16];
            s_tstamp_valid = 1'b1;
            do @(negedge clk); while (!s_tstamp_ready);
            @(posedge clk); #1;
        end
        s_tstamp_valid = 1'b0;
    endtask

    task automatic feed_data();
        foreach (dq[i]) begin
            s_data_data  = dq[i][15:0];
            s_data_last  = dq[i][16];
            s_data_valid = 1'b1;
            do @(negedge clk); while (!s_data_ready);
            @(posedge clk); #1;
        end
        s_data_valid = 1'b0;
    endtask

    task automatic rdy_gen(input bit rnd);
        if (rnd) forever begin
            @(posedge clk); #1;
            m_data_ready = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1; s_tstamp_valid = 1'b0; s_data_valid = 1'b0; m_data_ready = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic run(input int maxc, input bit rnd);
        int l0 = lasts;
        int t0 = cyc;
        got_q.delete(); got_cyc.delete();
        fork
            feed_ts();
            feed_data();
            rdy_gen(rnd);
        join_none
        while (lasts == l0 && (cyc - t0) < maxc) @(negedge clk);
        chk("completion", lasts != l0, 1);
        disable fork;
        s_tstamp_valid = 1'b0; s_data_valid = 1'b0; m_data_ready = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic cmp_seq(input string tag);
        chk({tag, " length"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("%s beat%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    task automatic setup_t1();
        ts_q = '{ts(100, 0, 0), ts(105, 3, 1)};
        dq   = '{bt(0,0), bt(1,0), bt(2,0), bt(3,0), bt(4,0), bt(5,1)};
        exp_q = '{ek(0,0), ek(1,0), ek(2,0), 18'h0, 18'h0, ek(3,0), ek(4,0), ek(5,1)};
    endtask

    initial begin
        int maxgap;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst m_data_valid", m_data_valid, 0);
        chk("rst m_data_last", m_data_last, 0);
        chk("rst m_kept", m_kept, 0);
        chk("rst error", error, 0);
        chk("rst s_tstamp_ready", s_tstamp_ready, 0);
        chk("rst s_data_ready", s_data_ready, 0);
        reset = 1'b0;

        // T1: dec=1, two fills between C and D
        cfg_decimation = 8'd1; setup_t1();
        run(200, 0); cmp_seq("t1"); chk("t1 error", error, 0);

        // T2: dec=4, three fills, exp_time ends at 28
        do_reset(); cfg_decimation = 8'd4;
        ts_q = '{ts(0, 0, 0), ts(20, 2, 1)};
        dq   = '{bt(0,0), bt(1,0), bt(2,0), bt(3,1)};
        exp_q = '{ek(0,0), ek(1,0), 18'h0, 18'h0, 18'h0, ek(2,0), ek(3,1)};
        run(200, 0); cmp_seq("t2"); chk("t2 error", error, 0);
        chk("t2 exp_time", dut.exp_time, 28);

        // T3: adjacent segments, no fill, at most 2 bubbles
        do_reset(); cfg_decimation = 8'd1;
        ts_q = '{ts(50, 0, 0), ts(52, 2, 1)};
        dq   = '{bt(0,0), bt(1,0), bt(2,0), bt(3,1)};
        exp_q = '{ek(0,0), ek(1,0), ek(2,0), ek(3,1)};
        run(200, 0); cmp_seq("t3");
        maxgap = 0;
        for (int i = 1; i < got_cyc.size(); i++)
            if (got_cyc[i] - got_cyc[i-1] > maxgap) maxgap = got_cyc[i] - got_cyc[i-1];
        chk("t3 bubble<=2", maxgap <= 3, 1);

        // T4: time wrap 254 -> 1
        do_reset(); cfg_decimation = 8'd1;
        ts_q = '{ts(254, 0, 0), ts(1, 2, 1)};
        dq   = '{bt(0,0), bt(1,0), bt(2,0), bt(3,1)};
        exp_q = '{ek(0,0), ek(1,0), 18'h0, ek(2,0), ek(3,1)};
        run(200, 0); cmp_seq("t4"); chk("t4 error", error, 0);

        // T5: first index nonzero
        do_reset(); cfg_decimation = 8'd1;
        ts_q = '{ts(10, 1, 1)};
        dq   = '{bt(0,0), bt(1,1)};
        exp_q = '{ek(0,0), ek(1,1)};
        run(200, 0); cmp_seq("t5"); chk("t5 error", error, 1);

        // T6: next record in the past -> error, no fill
        do_reset(); cfg_decimation = 8'd1;
        ts_q = '{ts(100, 0, 0), ts(101, 3, 1)};
        dq   = '{bt(0,0), bt(1,0), bt(2,0), bt(3,0), bt(4,1)};
        exp_q = '{ek(0,0), ek(1,0), ek(2,0), ek(3,0), ek(4,1)};
        run(200, 0); cmp_seq("t6"); chk("t6 error", error, 1);

        // T7: sparse stream ends early
        do_reset(); cfg_decimation = 8'd1;
        ts_q = '{ts(0, 0, 0), ts(10, 4, 1)};
        dq   = '{bt(0,0), bt(1,1)};
        exp_q = '{ek(0,0), ek(1,1)};
        run(200, 0); cmp_seq("t7"); chk("t7 error", error, 1);

        // T8: T1 with random backpressure
        do_reset(); cfg_decimation = 8'd1; setup_t1();
        run(600, 1); cmp_seq("t8"); chk("t8 error", error, 0);

        // T9: reset asserted mid-FILL
        do_reset(); cfg_decimation = 8'd1;
        ts_q = '{ts(0, 0, 0), ts(40, 1, 1)};
        dq   = '{bt(0,0), bt(1,1)};
        got_q.delete(); got_cyc.delete();
        fork
            feed_ts();
            feed_data();
        join_none
        for (int i = 0; i < 200 && got_q.size() < 6; i++) @(negedge clk);
        chk("t9 reached fill", got_q.size() >= 6, 1);
        disable fork;
        reset = 1'b1; s_tstamp_valid = 1'b0; s_data_valid = 1'b0;
        @(negedge clk);
        chk("t9 m_data_valid", m_data_valid, 0);
        chk("t9 m_data_last", m_data_last, 0);
        chk("t9 m_kept", m_kept, 0);
        chk("t9 error", error, 0);
        chk("t9 s_data_ready", s_data_ready, 0);
        if (got_q.size() >= 6) begin
            chk("t9 first", got_q[0], ek(0, 0));
            for (int i = 1; i < 6; i++) chk($sformatf("t9 fill%0d", i), got_q[i], 18'h0);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
